// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port 8 KB VRAM between the video fetcher,
// the CPU and the HDMA copier. Video has fixed priority; CPU and HDMA are
// round-robin arbitrated.
// Optional feature macro: VRAM_CPU_LOCK_EN locks the CPU out during PPU mode 3
// (reads return LOCK_DATA, writes dropped, HDMA stalls). Undefined: no lockout.
module vram_arbiter #(
  parameter int unsigned AW        = 13,
  parameter logic [7:0]  LOCK_DATA = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lcd_on,
  input  logic [1:0]    mode,
  input  logic          vid_rd,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_data,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_di,
  output logic [7:0]    cpu_do,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_di,
  output logic          dma_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_di,
  input  logic [7:0]    ram_do
);

  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;
  typedef enum logic {RR_CPU, RR_DMA} rr_t;

  owner_t     rd_owner, owner_d;
  rr_t        rr_ptr, rr_d;
  logic       cpu_busy, cpu_busy_d;
  logic       dma_busy, dma_busy_d;
  logic [7:0] cpu_do_q, cpu_do_d;
  logic [7:0] vid_data_q, vid_data_d;

  logic locked;
  logic vid_active;
  logic cpu_elig;
  logic dma_elig;
  logic cpu_lockout;
  logic grant_cpu;
  logic grant_dma;

`ifdef VRAM_CPU_LOCK_EN
  assign locked = lcd_on && (mode == 2'b11);
`else
  logic unused_mode;
  assign locked      = 1'b0;
  assign unused_mode = ^mode;
`endif

  // Winner selection, RAM port drive and next-state computation
  always_comb begin
    vid_active  = lcd_on && vid_rd;
    cpu_elig    = cpu_req && !locked && !cpu_busy;
    dma_elig    = dma_req && !locked && !dma_busy;
    cpu_lockout = cpu_req && locked && !cpu_busy;
    grant_cpu   = 1'b0;
    grant_dma   = 1'b0;
    rr_d        = rr_ptr;
    owner_d     = OWN_NONE;
    ram_addr    = '0;
    ram_we      = 1'b0;
    ram_di      = '0;

    if (vid_active) begin
      ram_addr = vid_addr;
      owner_d  = OWN_VID;
    end else if (cpu_elig && (!dma_elig || rr_ptr == RR_CPU)) begin
      grant_cpu = 1'b1;
      ram_addr  = cpu_addr;
      ram_we    = cpu_wr;
      ram_di    = cpu_wr ? cpu_di : 8'h00;
      if (dma_elig) rr_d = RR_DMA;
      if (!cpu_wr) owner_d = OWN_CPU;
    end else if (dma_elig) begin
      grant_dma = 1'b1;
      ram_addr  = dma_addr;
      ram_we    = 1'b1;
      ram_di    = dma_di;
      if (cpu_elig) rr_d = RR_CPU;
    end

    // Busy covers the ack cycle so a still-held request is not re-granted
    cpu_busy_d = grant_cpu || cpu_lockout;
    dma_busy_d = grant_dma;

    cpu_do_d = cpu_do_q;
    if (rd_owner == OWN_CPU)          cpu_do_d = ram_do;
    else if (cpu_lockout && !cpu_wr)  cpu_do_d = LOCK_DATA;

    vid_data_d = vid_data_q;
    if (rd_owner == OWN_VID) vid_data_d = ram_do;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner   <= OWN_NONE;
      rr_ptr     <= RR_CPU;
      cpu_busy   <= 1'b0;
      dma_busy   <= 1'b0;
      cpu_do_q   <= LOCK_DATA;
      vid_data_q <= 8'h00;
    end else begin
      rd_owner   <= owner_d;
      rr_ptr     <= rr_d;
      cpu_busy   <= cpu_busy_d;
      dma_busy   <= dma_busy_d;
      cpu_do_q   <= cpu_do_d;
      vid_data_q <= vid_data_d;
    end
  end

  // Read data is presented in the ack cycle straight from the RAM, then held;
  // a reset in that cycle discards the in-flight ack and data
  assign cpu_ack  = cpu_busy && !reset;
  assign dma_ack  = dma_busy && !reset;
  assign cpu_do   = (rd_owner == OWN_CPU && !reset) ? ram_do : cpu_do_q;
  assign vid_data = (rd_owner == OWN_VID && !reset) ? ram_do : vid_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM.
module tb_vram_arbiter;

`ifdef VRAM_CPU_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        lcd_on;
  logic [1:0]  mode;
  logic        vid_rd;
  logic [12:0] vid_addr;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_wr;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        cpu_ack;
  logic        dma_req;
  logic [12:0] dma_addr;
  logic [7:0]  dma_di;
  logic        dma_ack;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do;

  logic [7:0] mem [0:8191];
  int n_cmp = 0;
  int n_err = 0;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .lcd_on(lcd_on), .mode(mode),
    .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_do(cpu_do), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_di(dma_di), .dma_ack(dma_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  // Single-port synchronous VRAM, read-before-write
  always @(posedge clk) begin
    ram_do <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_di;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0000] = 8'h11;
    mem[13'h0010] = 8'h5A;
    ram_do   = 8'h00;
    reset    = 1'b1;
    lcd_on   = 1'b0;
    mode     = 2'b00;
    vid_rd   = 1'b0;
    vid_addr = '0;
    cpu_req  = 1'b0;
    cpu_wr   = 1'b0;
    cpu_addr = '0;
    cpu_di   = '0;
    dma_req  = 1'b0;
    dma_addr = '0;
    dma_di   = '0;

    // Reset state
    step(); step();
    chk("rst_cpu_ack_in_reset", 16'(cpu_ack), 16'h0);
    reset = 1'b0;
    step();
    chk("rst_cpu_ack", 16'(cpu_ack), 16'h0);
    chk("rst_dma_ack", 16'(dma_ack), 16'h0);
    chk("rst_cpu_do", 16'(cpu_do), 16'h00FF);
    chk("rst_vid_data", 16'(vid_data), 16'h0000);
    chk("rst_ram_we", 16'(ram_we), 16'h0);
    chk("rst_ram_addr", 16'(ram_addr), 16'h0000);

    // Idle CPU read with lcd off; vid_rd must be ignored
    vid_rd = 1'b1; vid_addr = 13'h1FFF;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h0010;
    #1;
    chk("rd_ram_addr", 16'(ram_addr), 16'h0010);
    chk("rd_ram_we", 16'(ram_we), 16'h0);
    step();
    chk("rd_cpu_ack", 16'(cpu_ack), 16'h1);
    chk("rd_cpu_do", 16'(cpu_do), 16'h005A);
    cpu_req = 1'b0; vid_rd = 1'b0;
    step();
    chk("rd_ack_drop", 16'(cpu_ack), 16'h0);
    chk("rd_cpu_do_held", 16'(cpu_do), 16'h005A);

    // CPU write delayed by three cycles of video fetch
    lcd_on = 1'b1; mode = 2'b00;
    vid_rd = 1'b1; vid_addr = 13'h0010;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h1800; cpu_di = 8'h3C;
    #1;
    chk("wv_c1_addr", 16'(ram_addr), 16'h0010);
    chk("wv_c1_we", 16'(ram_we), 16'h0);
    step();
    chk("wv_c2_we", 16'(ram_we), 16'h0);
    chk("wv_c2_vid_data", 16'(vid_data), 16'h005A);
    step();
    chk("wv_c3_we", 16'(ram_we), 16'h0);
    chk("wv_c3_ack", 16'(cpu_ack), 16'h0);
    step();
    vid_rd = 1'b0;
    #1;
    chk("wv_c4_we", 16'(ram_we), 16'h1);
    chk("wv_c4_addr", 16'(ram_addr), 16'h1800);
    chk("wv_c4_di", 16'(ram_di), 16'h003C);
    chk("wv_c4_ack", 16'(cpu_ack), 16'h0);
    step();
    chk("wv_c5_ack", 16'(cpu_ack), 16'h1);
    chk("wv_c5_we", 16'(ram_we), 16'h0);
    cpu_req = 1'b0;
    step();

    // CPU in mode 3: lockout read and dropped write (feature dependent)
    mode = 2'b11;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h0000;
    #1;
    chk("lk_rd_we", 16'(ram_we), 16'h0);
    step();
    chk("lk_rd_ack", 16'(cpu_ack), 16'h1);
    chk("lk_rd_do", 16'(cpu_do), LOCK_EN ? 16'h00FF : 16'h0011);
    cpu_req = 1'b0;
    step();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_di = 8'h77;
    #1;
    chk("lk_wr_we", 16'(ram_we), LOCK_EN ? 16'h0 : 16'h1);
    step();
    chk("lk_wr_ack", 16'(cpu_ack), 16'h1);
    cpu_req = 1'b0; mode = 2'b00;
    step();
    cpu_req = 1'b1; cpu_wr = 1'b0;
    step();
    chk("lk_readback", 16'(cpu_do), LOCK_EN ? 16'h0011 : 16'h0077);
    cpu_req = 1'b0;
    step();

    // HDMA under mode 3 stalls until the lock lifts
    mode = 2'b11;
    dma_req = 1'b1; dma_addr = 13'h0200; dma_di = 8'hA5;
`ifdef VRAM_CPU_LOCK_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dma_stall_we", 16'(ram_we), 16'h0);
      step();
      chk("dma_stall_ack", 16'(dma_ack), 16'h0);
    end
    mode = 2'b00;
`endif
    #1;
    chk("dma_we", 16'(ram_we), 16'h1);
    chk("dma_addr", 16'(ram_addr), 16'h0200);
    chk("dma_di", 16'(ram_di), 16'h00A5);
    step();
    chk("dma_ack", 16'(dma_ack), 16'h1);
    dma_req = 1'b0; mode = 2'b00;
    step();
    chk("dma_ack_drop", 16'(dma_ack), 16'h0);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h0200;
    step();
    chk("dma_readback", 16'(cpu_do), 16'h00A5);
    cpu_req = 1'b0;
    step();

    // Continuous CPU and HDMA requests alternate grants
    lcd_on = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h0300; cpu_di = 8'hC0;
    dma_req = 1'b1; dma_addr = 13'h0301; dma_di = 8'hD0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_addr", 16'(ram_addr), (k % 2 == 0) ? 16'h0300 : 16'h0301);
      chk("rr_we", 16'(ram_we), 16'h1);
      step();
      chk("rr_cpu_ack", 16'(cpu_ack), (k % 2 == 0) ? 16'h1 : 16'h0);
      chk("rr_dma_ack", 16'(dma_ack), (k % 2 == 0) ? 16'h0 : 16'h1);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    step();
    // Pointer now favours HDMA on the next simultaneous request
    cpu_req = 1'b1; dma_req = 1'b1;
    #1;
    chk("rr2_first", 16'(ram_addr), 16'h0301);
    step();
    chk("rr2_dma_ack", 16'(dma_ack), 16'h1);
    chk("rr2_cpu_wait", 16'(cpu_ack), 16'h0);
    chk("rr2_second", 16'(ram_addr), 16'h0300);
    step();
    chk("rr2_cpu_ack", 16'(cpu_ack), 16'h1);
    cpu_req = 1'b0; dma_req = 1'b0;
    step();

    // Reset right after a CPU read grant discards the access
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h0010;
    #1;
    chk("rs_grant_addr", 16'(ram_addr), 16'h0010);
    step();
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    chk("rs_ack_masked", 16'(cpu_ack), 16'h0);
    step();
    reset = 1'b0;
    chk("rs_cpu_ack", 16'(cpu_ack), 16'h0);
    chk("rs_cpu_do", 16'(cpu_do), 16'h00FF);
    chk("rs_vid_data", 16'(vid_data), 16'h0000);
    cpu_req = 1'b1; cpu_addr = 13'h1800;
    step();
    chk("rs_next_ack", 16'(cpu_ack), 16'h1);
    chk("rs_next_do", 16'(cpu_do), 16'h003C);
    cpu_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
